// File: rtl/count_hold_check.sv
// count_hold_check: receive-side monitor for the 4-bit count/hold/add result bus.
// Each clock it takes one sample (din, sel, a, b) and checks it against the rule
// for its mode. Outputs are registered and describe the sample taken at the
// previous edge: an error pulse with a cause code, a saturating error counter,
// the history-valid flag and the most recent sample that passed.
//
// Error cause codes on err_code (000 whenever err is low):
//   001  add mismatch     (sel=00, din != a + b)
//   010  count mismatch   (sel=10 after a sel=10 sample, din != prev_din + 1 mod 16)
//   011  hold mismatch    (sel=01 with valid history, din != prev_din)
//   100  illegal mode     (sel=11)
//
// There is no valid/ready handshake: every rising clock edge is a sample,
// and every output is valid for exactly the one cycle after that edge.
module count_hold_check #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active-low
    input  logic [3:0]       din,
    input  logic [1:0]       sel,
    input  logic [2:0]       a,
    input  logic [2:0]       b,
    input  logic             clr,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] err_cnt,
    output logic             locked,
    output logic [3:0]       last_good
);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    localparam logic [1:0] SEL_ADD   = 2'b00;
    localparam logic [1:0] SEL_HOLD  = 2'b01;
    localparam logic [1:0] SEL_COUNT = 2'b10;
    localparam logic [1:0] SEL_ILL   = 2'b11;

    localparam logic [2:0] CODE_NONE  = 3'b000;
    localparam logic [2:0] CODE_ADD   = 3'b001;
    localparam logic [2:0] CODE_COUNT = 3'b010;
    localparam logic [2:0] CODE_HOLD  = 3'b011;
    localparam logic [2:0] CODE_ILL   = 3'b100;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    logic [3:0]       r_prev_din;
    logic [1:0]       r_prev_sel;

    logic [3:0]       w_add_exp;
    logic [3:0]       w_count_exp;
    logic             w_fail;
    logic [2:0]       w_code;
    logic [CNT_W-1:0] w_cnt_base;
    logic [CNT_W-1:0] w_cnt_next;

    // Expected values: add is widened so 7+7=14 never truncates; count wraps 15->0.
    assign w_add_exp   = {1'b0, a} + {1'b0, b};
    assign w_count_exp = r_prev_din + 4'd1;

    // Classify the current sample; the case order gives the check priority.
    always_comb begin
        w_fail = 1'b0;
        w_code = CODE_NONE;
        case (sel)
            SEL_ILL: begin
                w_fail = 1'b1;
                w_code = CODE_ILL;
            end
            SEL_ADD: begin
                if (din != w_add_exp) begin
                    w_fail = 1'b1;
                    w_code = CODE_ADD;
                end
            end
            SEL_COUNT: begin
                // Only a count sample directly following another count sample
                // is checkable; a mode switch into count restarts tracking.
                if ((r_state == ST_LOCKED) && (r_prev_sel == SEL_COUNT) &&
                    (din != w_count_exp)) begin
                    w_fail = 1'b1;
                    w_code = CODE_COUNT;
                end
            end
            SEL_HOLD: begin
                if ((r_state == ST_LOCKED) && (din != r_prev_din)) begin
                    w_fail = 1'b1;
                    w_code = CODE_HOLD;
                end
            end
            default: begin
                w_fail = 1'b0;
                w_code = CODE_NONE;
            end
        endcase
    end

    // Counter next value: clear takes effect first, then a detected error adds one,
    // holding at all-ones instead of wrapping.
    always_comb begin
        w_cnt_base = clr ? '0 : err_cnt;
        w_cnt_next = w_cnt_base;
        if (w_fail && (w_cnt_base != CNT_MAX)) begin
            w_cnt_next = w_cnt_base + CNT_ONE;
        end
    end

    // Lock FSM, sample history and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_UNLOCKED;
            r_prev_din <= 4'd0;
            r_prev_sel <= 2'b00;
            err        <= 1'b0;
            err_code   <= CODE_NONE;
            err_cnt    <= '0;
            locked     <= 1'b0;
            last_good  <= 4'd0;
        end else begin
            r_prev_din <= din;
            r_prev_sel <= sel;
            err        <= w_fail;
            err_code   <= w_code;
            err_cnt    <= w_cnt_next;
            case (r_state)
                ST_UNLOCKED: begin
                    if (sel != SEL_ILL) begin
                        r_state <= ST_LOCKED;
                        locked  <= 1'b1;
                    end else begin
                        locked  <= 1'b0;
                    end
                end
                ST_LOCKED: begin
                    if (sel == SEL_ILL) begin
                        r_state <= ST_UNLOCKED;
                        locked  <= 1'b0;
                    end else begin
                        locked  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_UNLOCKED;
                    locked  <= 1'b0;
                end
            endcase
            // Illegal samples always fail, so !w_fail implies a legal mode.
            if (!w_fail) begin
                last_good <= din;
            end
        end
    end

endmodule

// File: tb/tb_count_hold_check.sv
// tb_count_hold_check: directed vector table, hand-written corner sequences
// (saturation, clear, asynchronous mid-stream reset) and a randomized run
// compared against a sample-history reference model.
module tb_count_hold_check;

  localparam int CNT_W = 8;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [3:0]       din;
  logic [1:0]       sel;
  logic [2:0]       a;
  logic [2:0]       b;
  logic             clr;
  logic             err;
  logic [2:0]       err_code;
  logic [CNT_W-1:0] err_cnt;
  logic             locked;
  logic [3:0]       last_good;

  int n_checks;
  int n_errors;

  count_hold_check #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .sel       (sel),
    .a         (a),
    .b         (b),
    .clr       (clr),
    .err       (err),
    .err_code  (err_code),
    .err_cnt   (err_cnt),
    .locked    (locked),
    .last_good (last_good)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0] sel;
    logic [3:0] din;
    logic [2:0] a;
    logic [2:0] b;
    logic       clr;
    logic       exp_err;
    logic [2:0] exp_code;
    logic       exp_locked;
    logic [3:0] exp_last_good;
    int         exp_cnt;
  } vec_t;

  localparam int NVEC = 17;
  vec_t tbl[NVEC];

  function automatic vec_t mk(input logic [1:0] s, input logic [3:0] d,
                              input logic [2:0] va, input logic [2:0] vb,
                              input logic c, input logic e, input logic [2:0] code,
                              input logic lk, input logic [3:0] lg, input int cnt);
    vec_t v;
    v.sel = s; v.din = d; v.a = va; v.b = vb; v.clr = c;
    v.exp_err = e; v.exp_code = code; v.exp_locked = lk;
    v.exp_last_good = lg; v.exp_cnt = cnt;
    return v;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0] sel;
    logic [3:0] din;
  } samp_t;

  samp_t hist[$];   // legal samples since the last reset or illegal sample
  int    m_err;
  int    m_code;
  int    m_cnt;
  int    m_locked;
  int    m_last_good;

  task automatic model_reset();
    hist.delete();
    m_err = 0; m_code = 0; m_cnt = 0; m_locked = 0; m_last_good = 0;
  endtask

  // Value a correct source would put on the bus for this mode; -1 = anything goes.
  function automatic int model_expected(input int s, input int va, input int vb);
    if (s == 0) return va + vb;
    if (s == 2 && hist.size() > 0 && hist[$].sel == 2'b10) return (hist[$].din + 1) % 16;
    if (s == 1 && hist.size() > 0) return hist[$].din;
    return -1;
  endfunction

  task automatic model_step(input int s, input int d, input int va, input int vb, input int c);
    int  exp_v;
    bit  fail;
    int  code;
    samp_t smp;
    exp_v = model_expected(s, va, vb);
    fail = 0;
    code = 0;
    if (s == 3) begin
      fail = 1; code = 4;
    end else if (exp_v >= 0 && d != exp_v) begin
      fail = 1;
      code = (s == 0) ? 1 : (s == 2) ? 2 : 3;
    end
    m_cnt = c ? 0 : m_cnt;
    if (fail && m_cnt < CNT_SAT) m_cnt = m_cnt + 1;
    m_err = fail ? 1 : 0;
    m_code = code;
    if (s == 3) begin
      hist.delete();
    end else begin
      smp.sel = 2'(s);
      smp.din = 4'(d);
      hist.push_back(smp);
      if (hist.size() > 4) void'(hist.pop_front());
    end
    m_locked = (hist.size() > 0) ? 1 : 0;
    if (!fail) m_last_good = d;
  endtask

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are read 1 ns after the rising edge.
  task automatic drive(input logic [1:0] s, input logic [3:0] d,
                       input logic [2:0] va, input logic [2:0] vb, input logic c);
    @(negedge clk);
    sel = s; din = d; a = va; b = vb; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int e, input int code,
                           input int lk, input int lg, input int cnt);
    check({tag, ".err"}, int'(err), e);
    check({tag, ".err_code"}, int'(err_code), code);
    check({tag, ".locked"}, int'(locked), lk);
    check({tag, ".last_good"}, int'(last_good), lg);
    check({tag, ".err_cnt"}, int'(err_cnt), cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    sel = 2'b00; din = 4'd0; a = 3'd0; b = 3'd0; clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int exp_sat;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; sel = 2'b00; din = 4'd0; a = 3'd0; b = 3'd0; clr = 1'b0;

    // Table from the reset state: add, count with wrap, hold, illegal, clear.
    tbl[0]  = mk(2'b00, 4'd14, 3'd7, 3'd7, 1'b0, 1'b0, 3'd0, 1'b1, 4'd14, 0);
    tbl[1]  = mk(2'b00, 4'd6,  3'd7, 3'd7, 1'b0, 1'b1, 3'd1, 1'b1, 4'd14, 1);
    tbl[2]  = mk(2'b10, 4'd13, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 4'd13, 1);
    tbl[3]  = mk(2'b10, 4'd14, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 4'd14, 1);
    tbl[4]  = mk(2'b10, 4'd15, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 4'd15, 1);
    tbl[5]  = mk(2'b10, 4'd0,  3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 4'd0,  1);
    tbl[6]  = mk(2'b10, 4'd1,  3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 4'd1,  1);
    tbl[7]  = mk(2'b10, 4'd3,  3'd0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b1, 4'd1,  2);
    tbl[8]  = mk(2'b00, 4'd5,  3'd2, 3'd3, 1'b0, 1'b0, 3'd0, 1'b1, 4'd5,  2);
    tbl[9]  = mk(2'b01, 4'd5,  3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 4'd5,  2);
    tbl[10] = mk(2'b01, 4'd5,  3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 4'd5,  2);
    tbl[11] = mk(2'b01, 4'd4,  3'd0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b1, 4'd5,  3);
    tbl[12] = mk(2'b11, 4'd9,  3'd0, 3'd0, 1'b0, 1'b1, 3'd4, 1'b0, 4'd5,  4);
    tbl[13] = mk(2'b01, 4'd9,  3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 4'd9,  4);
    tbl[14] = mk(2'b10, 4'd2,  3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 4'd2,  4);
    tbl[15] = mk(2'b10, 4'd3,  3'd0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1, 4'd3,  0);
    tbl[16] = mk(2'b00, 4'd3,  3'd1, 3'd1, 1'b1, 1'b1, 3'd1, 1'b1, 4'd3,  1);

    do_reset();
    #1;
    check_all("reset", 0, 0, 0, 0, 0);

    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].sel, tbl[i].din, tbl[i].a, tbl[i].b, tbl[i].clr);
      check_all($sformatf("vec%0d", i), int'(tbl[i].exp_err), int'(tbl[i].exp_code),
                int'(tbl[i].exp_locked), int'(tbl[i].exp_last_good), tbl[i].exp_cnt);
    end

    // Saturation: 300 back-to-back add mismatches, counter stops at 2^CNT_W-1.
    exp_sat = 1;
    for (int i = 0; i < 300; i++) begin
      drive(2'b00, 4'd1, 3'd0, 3'd0, 1'b0);
      exp_sat = (exp_sat < CNT_SAT) ? exp_sat + 1 : CNT_SAT;
      check("sat.err", int'(err), 1);
      check("sat.err_cnt", int'(err_cnt), exp_sat);
    end
    drive(2'b00, 4'd1, 3'd0, 3'd0, 1'b1);
    check_all("clr_with_err", 1, 1, 1, 3, 1);
    drive(2'b00, 4'd0, 3'd0, 3'd0, 1'b1);
    check_all("clr_alone", 0, 0, 1, 0, 0);

    // Asynchronous reset between edges in count mode, then first count sample unchecked.
    drive(2'b10, 4'd4, 3'd0, 3'd0, 1'b0);
    drive(2'b10, 4'd6, 3'd0, 3'd0, 1'b0);
    check_all("pre_rst", 1, 2, 1, 4, 1);
    #2;
    rst = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    drive(2'b10, 4'd7, 3'd0, 3'd0, 1'b0);
    check_all("post_rst", 0, 0, 1, 7, 0);

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int i = 0; i < 2000; i++) begin
      int s, va, vb, d, c, ev;
      s  = int'($urandom_range(0, 15));
      s  = (s < 5) ? 0 : (s < 10) ? 2 : (s < 14) ? 1 : 3;
      va = int'($urandom_range(0, 7));
      vb = int'($urandom_range(0, 7));
      ev = model_expected(s, va, vb);
      d  = ($urandom_range(0, 3) != 0 && ev >= 0) ? ev : int'($urandom_range(0, 15));
      c  = ($urandom_range(0, 15) == 0) ? 1 : 0;
      drive(2'(s), 4'(d), 3'(va), 3'(vb), 1'(c));
      model_step(s, d, va, vb, c);
      check_all("rand", m_err, m_code, m_locked, m_last_good, m_cnt);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/count_hold_check.md
# count_hold_check

Receive-side checker for the 4-bit count/hold/add result bus. It samples the result value together with the mode select and the adder operands on every clock, and verifies that each sample is consistent with the selected mode. Mismatches are reported as a registered error pulse with a cause code and accumulated in a saturating error counter. It sits at the consuming end of the result bus, used in-system and as a bench monitor.

## Interface
- CNT_W, 8, width of the saturating error counter
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (0 = reset asserted)
- din  input  4  sampled result value
- sel  input  2  mode qualifying din: 00 add, 10 count, 01 hold, 11 illegal
- a  input  3  adder operand A for the same cycle
- b  input  3  adder operand B for the same cycle
- clr  input  1  synchronous clear of err_cnt
- err  output  1  one-cycle pulse: previous-cycle sample failed its check
- err_code  output  3  cause of the current err pulse; 000 when err=0
- err_cnt  output  CNT_W  saturating count of detected errors
- locked  output  1  history valid (state LOCKED)
- last_good  output  4  most recent sample that passed its check

## Operation
- States: UNLOCKED (no valid previous sample), LOCKED.
- Sample registers prev_din[3:0], prev_sel[1:0], updated every cycle with din/sel.
- Per-sample checks, priority top-down:
  - sel=11: error, code 100; next state UNLOCKED.
  - sel=00: expected = {1'b0,a} + {1'b0,b}, 4-bit, no truncation (max 7+7=14). din≠expected -> code 001. Checked in either state.
  - sel=10: checked only if LOCKED and prev_sel=10; expected = prev_din+1 mod 16 (15 -> 0 is legal wrap). Mismatch -> code 010. Otherwise not checked.
  - sel=01: checked only if LOCKED; expected = prev_din. Mismatch -> code 011.
- Any sample with legal sel (00/10/01): next state LOCKED, regardless of pass/fail.
- Sample passes (checked and matched, or not checkable with legal sel): last_good <= din. Failing or illegal samples leave last_good unchanged.
- err_cnt: +1 per error, saturates at 2^CNT_W-1 (no wrap).
- clr=1: err_cnt <= 0; if an error is detected in the same cycle, err_cnt <= 1 (clr applied first, then increment).
- clr does not affect state, err, err_code, or last_good.

## Timing
- All outputs registered; err/err_code/err_cnt/last_good/locked reflect the sample taken at edge N after edge N+1... i.e., valid in the cycle following the sampling edge.
- err is high exactly one cycle per failing sample; back-to-back failures give back-to-back pulses.
- Reset (rst=0, asynchronous, any time incl. mid-stream): state UNLOCKED, err=0, err_code=000, err_cnt=0, locked=0, last_good=0000, prev_din=0000, prev_sel=00. First sample after release is never a count/hold check.
- Count check uses the immediately preceding sample only; a mode switch 00/01 -> 10 restarts count tracking (no check on the first count sample).
- Latency from sample to err: 1 clock.

## Test plan
- Reset then sel=00, a=7, b=7, din=14 -> err=0, locked=1, last_good=14; repeat with din=6 -> err=1, err_code=001, err_cnt=1.
- sel=10, din 13,14,15,0,1 -> no err (wrap 15->0 accepted), last_good=1; then din=3 -> err=1, code 010.
- sel=00 din=5 (a=2,b=3), then sel=01 din=5,5 -> no err; then sel=01 din=4 -> err=1, code 011, last_good stays 5.
- sel=11 any din -> err=1, code 100, locked=0 next cycle; following sel=01 din=9 -> no err, locked=1.
- Force 300 consecutive add mismatches with CNT_W=8 -> err_cnt stops at 255; assert clr with one more mismatch -> err_cnt=1; clr alone -> 0.
- Mid-stream rst=0 pulse between clock edges during count mode -> all outputs zero immediately; after release sel=10 din=7 -> no err (first sample unchecked).
